// File: rtl/brisc_mem_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package brisc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int MEM_LAT_DEF = 1;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory command bus seen by mem_arbiter.
// Handshake: a requester raises req with a stable command and holds it until its
// one-cycle gnt pulse; load data is valid only in the one-cycle rvalid pulse.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side.
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters and memory side.
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise data has fixed priority.
module arb_pick
  import brisc_mem_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output logic   valid,
  output owner_t winner
);

  assign valid = if_req | d_req;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner = OWN_D;
    if (if_req && d_req) begin
      winner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
    end else if (if_req) begin
      winner = OWN_IF;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  assign winner = (if_req && !d_req) ? OWN_IF : OWN_D;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Optional MEM_ARB_RR_EN: round-robin tie-break instead of data-first priority.
module mem_arbiter
  import brisc_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.master  bus,
  output state_t         dbg_state
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_t           state_q;
  owner_t           owner_q;
  owner_t           last_owner;
  owner_t           pick_owner;
  logic             pick_valid;
  logic             launch;
  logic             rvalid_next;
  logic [CNT_W-1:0] cnt_q;
  logic             if_gnt_q, d_gnt_q, if_rvalid_q, d_rvalid_q;
  logic             mem_en_q, mem_we_q;
  logic [AW-1:0]    mem_addr_q;
  logic [DW-1:0]    mem_wdata_q;

  arb_pick u_pick (
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .winner     (pick_owner)
  );

  // Arbitration slots: IDLE, and the rvalid cycle of WAIT so loads can run back to back.
  assign launch = pick_valid &&
                  ((state_q == IDLE) || ((state_q == WAIT) && (cnt_q == '0)));

  // Registered rvalid lands in the cycle where WAIT reaches cnt == 0.
  assign rvalid_next = ((state_q == ISSUE) && !mem_we_q && (CNT_INIT == '0)) ||
                       ((state_q == WAIT) && (cnt_q == CNT_W'(1)));

`ifdef MEM_ARB_RR_EN
  owner_t last_owner_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_q <= OWN_IF;
    end else if (state_q == ISSUE) begin
      last_owner_q <= owner_q;
    end
  end

  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_IF;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_D;
      cnt_q       <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= rvalid_next && (owner_q == OWN_IF);
      d_rvalid_q  <= rvalid_next && (owner_q == OWN_D);

      if (launch) begin
        state_q  <= ISSUE;
        owner_q  <= pick_owner;
        mem_en_q <= 1'b1;
        if (pick_owner == OWN_D) begin
          d_gnt_q     <= 1'b1;
          mem_we_q    <= bus.d_we;
          mem_addr_q  <= bus.d_addr;
          mem_wdata_q <= bus.d_wdata;
        end else begin
          if_gnt_q    <= 1'b1;
          mem_addr_q  <= bus.if_addr;
          mem_wdata_q <= '0;
        end
      end else begin
        case (state_q)
          ISSUE: begin
            // mem_we_q is still high here for a store.
            if (mem_we_q) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= CNT_INIT;
              state_q <= WAIT;
            end
          end
          WAIT: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end else begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=1 instance (dut_a) and MEM_LAT=3 instance (dut_b).
// The memory model returns the bitwise inverse of the last read address.
module tb_mem_arbiter;
  import brisc_mem_pkg::*;

  logic   clk;
  logic   rst;
  state_t st_a, st_b;
  int     n_cmp = 0;
  int     n_err = 0;

  mem_arbiter_if #(.AW(32), .DW(32)) bus_a ();
  mem_arbiter_if #(.AW(32), .DW(32)) bus_b ();

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .dbg_state(st_a)
  );
  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .dbg_state(st_b)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory model ----------------
  logic [31:0] rd_addr_a, rd_addr_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_a <= '0;
      rd_addr_b <= '0;
    end else begin
      if (bus_a.mem_en && !bus_a.mem_we) rd_addr_a <= bus_a.mem_addr;
      if (bus_b.mem_en && !bus_b.mem_we) rd_addr_b <= bus_b.mem_addr;
    end
  end
  assign bus_a.mem_rdata = ~rd_addr_a;
  assign bus_b.mem_rdata = ~rd_addr_b;

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.if_req = 0; bus_a.if_addr = '0; bus_a.d_req = 0; bus_a.d_we = 0;
    bus_a.d_addr = '0; bus_a.d_wdata = '0;
    bus_b.if_req = 0; bus_b.if_addr = '0; bus_b.d_req = 0; bus_b.d_we = 0;
    bus_b.d_addr = '0; bus_b.d_wdata = '0;
  endtask

  // ---------------- scoreboard for grant order ----------------
  logic [0:0] exp_q[$];   // 1 = data owner, 0 = fetch owner
  logic [0:0] exp_own;
  int         n_gnt;
  int         gcyc[4];
  logic       seen;

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();

    // Reset state
    check_eq("rst_outs_a", {bus_a.if_gnt, bus_a.d_gnt, bus_a.if_rvalid, bus_a.d_rvalid,
                            bus_a.mem_en, bus_a.mem_we}, 64'h0);
    check_eq("rst_addr_a", bus_a.mem_addr, 64'h0);
    check_eq("rst_wdata_a", bus_a.mem_wdata, 64'h0);
    check_eq("rst_state_a", 64'(st_a), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Fetch read, MEM_LAT=1
    bus_a.if_req = 1; bus_a.if_addr = 32'h10;
    tick();
    check_eq("fr_gnt", {bus_a.if_gnt, bus_a.mem_en, bus_a.mem_we, bus_a.d_gnt}, 64'b1100);
    check_eq("fr_addr", bus_a.mem_addr, 64'h10);
    bus_a.if_req = 0;
    tick();
    check_eq("fr_rvalid", {bus_a.if_rvalid, bus_a.d_rvalid, bus_a.if_gnt, bus_a.mem_en}, 64'b1000);
    check_eq("fr_rdata", bus_a.if_rdata, 64'hFFFF_FFEF);
    tick();
    check_eq("fr_done", {bus_a.if_rvalid, bus_a.d_gnt, bus_a.d_rvalid}, 64'b000);
    check_eq("fr_state", 64'(st_a), 64'(IDLE));

    // Store
    bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_addr = 32'h200; bus_a.d_wdata = 32'hDEAD_BEEF;
    tick();
    check_eq("st_cmd", {bus_a.mem_en, bus_a.mem_we, bus_a.d_gnt, bus_a.if_gnt}, 64'b1110);
    check_eq("st_addr", bus_a.mem_addr, 64'h200);
    check_eq("st_wdata", bus_a.mem_wdata, 64'hDEAD_BEEF);
    bus_a.d_req = 0; bus_a.d_we = 0;
    tick();
    check_eq("st_after", {bus_a.d_gnt, bus_a.mem_en, bus_a.mem_we, bus_a.d_rvalid}, 64'b0000);
    check_eq("st_state", 64'(st_a), 64'(IDLE));
    tick();
    check_eq("st_norv", bus_a.d_rvalid, 64'h0);

    // Tie on loads, fresh from reset so data wins first in either build
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 32'h300;
    bus_a.if_req = 1; bus_a.if_addr = 32'h40;
    tick();
    check_eq("tie_dgnt", {bus_a.d_gnt, bus_a.if_gnt}, 64'b10);
    check_eq("tie_daddr", bus_a.mem_addr, 64'h300);
    bus_a.d_req = 0;
    tick();
    check_eq("tie_drv", {bus_a.d_rvalid, bus_a.if_gnt}, 64'b10);
    check_eq("tie_drdata", bus_a.d_rdata, 64'hFFFF_FCFF);
    tick();
    check_eq("tie_ifgnt", {bus_a.if_gnt, bus_a.mem_en}, 64'b11);
    check_eq("tie_ifaddr", bus_a.mem_addr, 64'h40);
    bus_a.if_req = 0;
    tick();
    check_eq("tie_ifrv", bus_a.if_rvalid, 64'h1);
    check_eq("tie_ifrdata", bus_a.if_rdata, 64'hFFFF_FFBF);
    tick();

    // Both requesters held for four load transactions
`ifdef MEM_ARB_RR_EN
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
`else
    exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
`endif
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 32'h300;
    bus_a.if_req = 1; bus_a.if_addr = 32'h40;
    n_gnt = 0;
    for (int c = 0; c < 40 && n_gnt < 4; c++) begin
      tick();
      if (bus_a.d_gnt || bus_a.if_gnt) begin
        exp_own = exp_q.pop_front();
        check_eq($sformatf("hold_own%0d", n_gnt), 64'(bus_a.d_gnt), 64'(exp_own));
        gcyc[n_gnt] = c;
        n_gnt++;
        if (n_gnt == 4) begin
          bus_a.d_req = 0;
          bus_a.if_req = 0;
        end
      end
    end
    check_eq("hold_count", n_gnt, 64'd4);
    for (int i = 1; i < 4; i++) begin
      if (i < n_gnt) check_eq($sformatf("hold_gap%0d", i), gcyc[i] - gcyc[i-1], 64'd2);
    end
    tick();
    tick();
    check_eq("hold_state", 64'(st_a), 64'(IDLE));

    // MEM_LAT=3 load with fetch pending
    bus_b.d_req = 1; bus_b.d_we = 0; bus_b.d_addr = 32'h80;
    bus_b.if_req = 1; bus_b.if_addr = 32'h44;
    tick();
    check_eq("l3_dgnt", {bus_b.d_gnt, bus_b.if_gnt, bus_b.mem_en}, 64'b101);
    check_eq("l3_addr", bus_b.mem_addr, 64'h80);
    bus_b.d_req = 0;
    seen = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      seen = seen | bus_b.mem_en | bus_b.if_gnt;
      check_eq($sformatf("l3_drv_c%0d", k), bus_b.d_rvalid, 64'(k == 4));
    end
    check_eq("l3_no_cmd", seen, 64'h0);
    check_eq("l3_rdata", bus_b.d_rdata, 64'hFFFF_FF7F);
    tick();
    check_eq("l3_ifgnt", {bus_b.if_gnt, bus_b.mem_en}, 64'b11);
    check_eq("l3_ifaddr", bus_b.mem_addr, 64'h44);
    bus_b.if_req = 0;
    tick();
    tick();
    tick();
    check_eq("l3_ifrv", bus_b.if_rvalid, 64'h1);
    check_eq("l3_ifrdata", bus_b.if_rdata, 64'hFFFF_FFBB);
    tick();

    // Reset in the middle of WAIT
    bus_b.if_req = 1; bus_b.if_addr = 32'h20;
    tick();
    check_eq("mr_gnt", bus_b.if_gnt, 64'h1);
    bus_b.if_req = 0;
    tick();
    check_eq("mr_wait", 64'(st_b), 64'(WAIT));
    #2;
    rst = 1'b1;
    #1;
    check_eq("mr_outs", {bus_b.if_gnt, bus_b.d_gnt, bus_b.if_rvalid, bus_b.d_rvalid,
                         bus_b.mem_en, bus_b.mem_we}, 64'h0);
    check_eq("mr_addr", bus_b.mem_addr, 64'h0);
    check_eq("mr_state", 64'(st_b), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen = seen | bus_b.if_rvalid | bus_b.d_rvalid | bus_b.if_gnt | bus_b.d_gnt;
    end
    check_eq("mr_quiet", seen, 64'h0);
    bus_b.d_req = 1; bus_b.d_we = 0; bus_b.d_addr = 32'h24;
    tick();
    check_eq("mr_regnt", {bus_b.d_gnt, bus_b.mem_en}, 64'b11);
    check_eq("mr_readdr", bus_b.mem_addr, 64'h24);
    bus_b.d_req = 0;
    tick();
    tick();
    tick();
    check_eq("mr_drv", bus_b.d_rvalid, 64'h1);
    check_eq("mr_rdata", bus_b.d_rdata, 64'hFFFF_FFDB);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
